// File: rtl/tdm_pkg.sv
// Shared types and constants for the four-channel TDM demultiplexer family.
package tdm_pkg;

  localparam int unsigned SLOT_W = 2;
  localparam int unsigned NUM_CH = 4;

  typedef logic [SLOT_W-1:0] slot_t;

  // Frame alignment state: hunting for a sync beat, or locked to frames.
  typedef enum logic [0:0] {
    StHunt = 1'b0,
    StLock = 1'b1
  } tdm_state_e;

endpackage

// File: rtl/demux1_4.sv
// Slot decoder: turns a 2-bit slot index plus a load qualifier into one-hot capture enables.
module demux1_4
  import tdm_pkg::*;
(
  input  logic [SLOT_W-1:0] sel,
  input  logic              load,
  output logic [NUM_CH-1:0] en
);

  // One enable per channel; all low when nothing is being loaded.
  always_comb begin
    en = '0;
    if (load) begin
      en[sel] = 1'b1;
    end
  end

endmodule

// File: rtl/tdm_demux4.sv
// Four-channel TDM receive demultiplexer. Locks to the sync-marked frame, collects slots 0..2
// in shadow registers and publishes all four channels together on the slot-3 beat.
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             sync,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic             frame_valid,
  output logic             locked,
  output logic             sync_err
);

  tdm_state_e        state_q, state_d;
  slot_t             slot_q, slot_d;
  logic              err_d;
  logic              cap_load;
  slot_t             cap_slot;
  logic [NUM_CH-1:0] cap_en;

  logic [WIDTH-1:0]  s0_q, s1_q, s2_q;
  logic [WIDTH-1:0]  y0_q, y1_q, y2_q, y3_q;
  logic              frame_valid_q;
  logic              sync_err_q;

  // Frame alignment: decide which slot (if any) this beat fills and where the counter goes.
  // A sync beat always restarts the frame at slot 0; it is only an error when it arrives early.
  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    err_d    = 1'b0;
    cap_load = 1'b0;
    cap_slot = '0;
    if (din_valid) begin
      unique case (state_q)
        StHunt: begin
          if (sync) begin
            cap_load = 1'b1;
            state_d  = StLock;
            slot_d   = slot_t'(1);
          end
        end
        StLock: begin
          if (sync) begin
            cap_load = 1'b1;
            slot_d   = slot_t'(1);
            err_d    = (slot_q != '0);
          end else if (slot_q == '0) begin
            // Expected sync never came: drop the beat and re-acquire.
            err_d   = 1'b1;
            state_d = StHunt;
            slot_d  = '0;
          end else begin
            cap_load = 1'b1;
            cap_slot = slot_q;
            slot_d   = slot_q + slot_t'(1);
          end
        end
        default: begin
          state_d = StHunt;
          slot_d  = '0;
        end
      endcase
    end
  end

  demux1_4 u_demux (
    .sel  (cap_slot),
    .load (cap_load),
    .en   (cap_en)
  );

  // State, shadow and output registers; the slot-3 capture publishes the whole frame at once.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= StHunt;
      slot_q        <= '0;
      s0_q          <= '0;
      s1_q          <= '0;
      s2_q          <= '0;
      y0_q          <= '0;
      y1_q          <= '0;
      y2_q          <= '0;
      y3_q          <= '0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      sync_err_q    <= err_d;
      frame_valid_q <= cap_en[3];
      if (cap_en[0]) s0_q <= din;
      if (cap_en[1]) s1_q <= din;
      if (cap_en[2]) s2_q <= din;
      if (cap_en[3]) begin
        y0_q <= s0_q;
        y1_q <= s1_q;
        y2_q <= s2_q;
        y3_q <= din;
      end
    end
  end

  assign y0          = y0_q;
  assign y1          = y1_q;
  assign y2          = y2_q;
  assign y3          = y3_q;
  assign frame_valid = frame_valid_q;
  assign sync_err    = sync_err_q;
  assign locked      = (state_q == StLock);

endmodule

// File: tb/tb_tdm_demux4.sv
// Scoreboard bench for tdm_demux4: a frame-level reference model predicts each published frame
// and each framing error; a monitor compares DUT outputs one cycle after each beat.
module tb_tdm_demux4;

  localparam int unsigned W = 8;

  logic         clock = 1'b0;
  logic         reset;
  logic [W-1:0] din;
  logic         din_valid;
  logic         sync;
  logic [W-1:0] y0, y1, y2, y3;
  logic         frame_valid, locked, sync_err;

  int tests = 0;
  int fails = 0;

  tdm_demux4 #(.WIDTH(W)) dut (
    .clock       (clock),
    .reset       (reset),
    .din         (din),
    .din_valid   (din_valid),
    .sync        (sync),
    .y0          (y0),
    .y1          (y1),
    .y2          (y2),
    .y3          (y3),
    .frame_valid (frame_valid),
    .locked      (locked),
    .sync_err    (sync_err)
  );

  always #5 clock = ~clock;

  // Reference model: lock flag plus the samples of the frame under construction.
  logic           m_locked = 1'b0;
  logic [W-1:0]   part[$];
  logic [4*W-1:0] frame_q[$];
  logic           exp_fv = 1'b0, exp_err = 1'b0, exp_rst = 1'b0, exp_locked = 1'b0;

  task automatic model_step(input logic r, input logic v, input logic [W-1:0] d,
                            input logic s);
    exp_fv  = 1'b0;
    exp_err = 1'b0;
    exp_rst = 1'b0;
    if (r) begin
      m_locked = 1'b0;
      part.delete();
      exp_rst = 1'b1;
    end else if (v) begin
      if (!m_locked) begin
        if (s) begin
          m_locked = 1'b1;
          part.delete();
          part.push_back(d);
        end
      end else if (s) begin
        if (part.size() != 0) exp_err = 1'b1;
        part.delete();
        part.push_back(d);
      end else if (part.size() == 0) begin
        exp_err  = 1'b1;
        m_locked = 1'b0;
      end else begin
        part.push_back(d);
        if (part.size() == 4) begin
          frame_q.push_back({part[3], part[2], part[1], part[0]});
          exp_fv = 1'b1;
          part.delete();
        end
      end
    end
    exp_locked = m_locked;
  endtask

  task automatic drive(input logic r, input logic v, input logic [W-1:0] d, input logic s);
    @(negedge clock);
    reset     = r;
    din_valid = v;
    din       = d;
    sync      = s;
    model_step(r, v, d, s);
  endtask

  task automatic beat(input logic [W-1:0] d, input logic s);
    drive(1'b0, 1'b1, d, s);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, W'($urandom), 1'($urandom));
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Monitor: one cycle after each edge, pop the predicted frame (if any) and compare everything.
  logic [4*W-1:0] hold = '0;
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (exp_rst) begin
        hold = '0;
        frame_q.delete();
      end
      if (exp_fv) begin
        if (frame_q.size() == 0) begin
          chk("frame_q_underflow", 32'd0, 32'd1);
        end else begin
          hold = frame_q.pop_front();
        end
      end
      chk("frame_valid", 32'(frame_valid), 32'(exp_fv));
      chk("sync_err", 32'(sync_err), 32'(exp_err));
      chk("locked", 32'(locked), 32'(exp_locked));
      chk("y0", 32'(y0), 32'(hold[0*W +: W]));
      chk("y1", 32'(y1), 32'(hold[1*W +: W]));
      chk("y2", 32'(y2), 32'(hold[2*W +: W]));
      chk("y3", 32'(y3), 32'(hold[3*W +: W]));
    end
  end

  initial begin
    logic s;
    reset     = 1'b1;
    din_valid = 1'b0;
    din       = '0;
    sync      = 1'b0;
    model_step(1'b1, 1'b0, '0, 1'b0);
    drive(1'b1, 1'b0, '0, 1'b0);
    drive(1'b1, 1'b1, 8'h55, 1'b1);

    // Basic frame.
    beat(8'h01, 1'b1); beat(8'h02, 1'b0); beat(8'h03, 1'b0); beat(8'h04, 1'b0);
    idle(2);
    // Two back-to-back frames.
    beat(8'hA0, 1'b1); beat(8'hA1, 1'b0); beat(8'hA2, 1'b0); beat(8'hA3, 1'b0);
    beat(8'hB0, 1'b1); beat(8'hB1, 1'b0); beat(8'hB2, 1'b0); beat(8'hB3, 1'b0);
    // Gaps between beats; counter must hold.
    beat(8'hC0, 1'b1); idle(3); beat(8'hC1, 1'b0); idle(3);
    beat(8'hC2, 1'b0); beat(8'hC3, 1'b0);
    // Early sync on the second beat of a frame.
    beat(8'hD0, 1'b1); beat(8'hD1, 1'b0); beat(8'hE0, 1'b1);
    beat(8'hE1, 1'b0); beat(8'hE2, 1'b0); beat(8'hE3, 1'b0);
    // Missing sync after a full frame, then unsynced beats ignored in HUNT.
    beat(8'h70, 1'b0); beat(8'h71, 1'b0); beat(8'h72, 1'b0); idle(1);
    beat(8'h80, 1'b1); beat(8'h81, 1'b0); beat(8'h82, 1'b0); beat(8'h83, 1'b0);
    // Reset mid-frame, beat during reset ignored, then a fresh frame.
    beat(8'h90, 1'b1); beat(8'h91, 1'b0);
    drive(1'b1, 1'b1, 8'h92, 1'b0);
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    beat(8'h93, 1'b0); beat(8'h94, 1'b0);
    beat(8'hF0, 1'b1); beat(8'hF1, 1'b0); beat(8'hF2, 1'b0); beat(8'hF3, 1'b0);

    // Random traffic with mostly-correct framing and occasional violations and resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        drive(1'b1, 1'($urandom), W'($urandom), 1'($urandom));
      end else if ($urandom_range(0, 9) < 3) begin
        drive(1'b0, 1'b0, W'($urandom), 1'($urandom));
      end else begin
        if (!m_locked) s = ($urandom_range(0, 3) != 0);
        else if (part.size() == 0) s = ($urandom_range(0, 19) != 0);
        else s = ($urandom_range(0, 15) == 0);
        beat(W'($urandom), s);
      end
    end

    idle(3);
    @(posedge clock);
    #2;
    chk("frame_q_drained", 32'(frame_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tdm_demux4.md
# tdm_demux4

Four-channel time-division demultiplexer, the receive-side counterpart of the team's 4:1 multiplexer. Accepts a single stream carrying one sample per valid beat, with a sync flag marking channel 0. Locks to the frame and steers each sample into its channel register. Presents all four channels together, updated atomically once per complete frame, with a one-cycle frame strobe.

## Interface
- WIDTH, 1: sample width in bits, for channels and stream alike.
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- din  in  WIDTH  stream sample.
- din_valid  in  1  din/sync are meaningful this cycle (one beat).
- sync  in  1  qualified by din_valid; marks the beat carrying channel 0.
- y0, y1, y2, y3  out  WIDTH  channel outputs, registered.
- frame_valid  out  1  one-cycle pulse: y0..y3 just updated with a new complete frame.
- locked  out  1  high while the block is aligned to frames.
- sync_err  out  1  one-cycle pulse on a framing violation.

## Operation
- States: HUNT, LOCK. A 2-bit slot counter (0..3) is valid only in LOCK.
- Only beats with din_valid=1 are acted on. sync without din_valid is ignored.
- HUNT:
  - A beat with sync=0 is discarded.
  - A beat with sync=1 is captured as slot 0. Go to LOCK with slot=1.
- LOCK, beat at expected slot k, with k in 1..3 and sync=0:
  - Capture into channel k. slot increments mod 4.
- LOCK, beat at expected slot 0:
  - sync=1: capture as slot 0, slot=1.
  - sync=0: lost frame. Pulse sync_err, discard the beat, return to HUNT.
- LOCK, beat at expected slot 1..3 with sync=1 (early sync):
  - Pulse sync_err and discard the partial frame.
  - Capture the beat as slot 0, slot=1, stay in LOCK.
- Slots 0..2 go into shadow registers s0..s2.
- On the slot-3 capture, the same edge does all of the following:
  - y0<=s0, y1<=s1, y2<=s2, y3<=din.
  - frame_valid<=1.
- Outputs never show a mix of two frames. y0..y3 hold their value between frames and across HUNT.
- locked = (state==LOCK).

## Timing
- Reset values: y0..y3=0, frame_valid=0, sync_err=0, locked=0, state=HUNT, slot=0, s0..s2=0.
- Reset asserted mid-frame wins over any beat in the same cycle. The partial frame is lost.
- Latency: slot-3 beat sampled at edge N → y0..y3 and frame_valid visible after edge N. frame_valid is high for exactly that one cycle.
- sync_err is high for the one cycle after the offending edge.
- locked rises after the edge that accepts the first sync beat. It falls after the edge that detects a missing sync.
- Back-to-back frames at full rate (din_valid held high) give frame_valid every 4th cycle with no bubbles.
- Idle cycles (din_valid=0) between beats are allowed anywhere. The slot counter holds during them.
- Wrap: slot 3 → 0 is mod-4 and needs no special case.

## Structure
- Shared package tdm_pkg holds:
  - state typedef/encoding: HUNT=1'b0, LOCK=1'b1.
  - SLOT_W=2 and NUM_CH=4.
- Sub-module demux1_4: combinational decoder from slot[1:0] plus a load qualifier to four one-hot capture enables. Reused from the team's mux/demux family.
- The top level holds the FSM, slot counter, shadow registers and output registers.

## Test plan
- Reset, then 4 valid beats 0x1,0x2,0x3,0x4 (WIDTH=4) with sync on the first → y0..y3=1,2,3,4 and frame_valid pulses one cycle after the 4th beat. locked=1 from the cycle after beat 1.
- 8 continuous beats A0..A3,B0..B3, sync on A0 and B0 → frame_valid twice, 4 cycles apart. Outputs show A's values, then B's, never mixed.
- Beats at slots 0,1 with din_valid gaps of 3 cycles each, then slots 2,3 → single correct frame. Slot counter holds across gaps.
- Early sync: sync on beats 1 and 3 (slots 0,1,0,...) → sync_err pulse at beat 3, previous y values unchanged, new frame starts at beat 3, locked stays 1.
- Missing sync at the expected slot 0 after a full frame → sync_err pulse, locked=0, beat discarded. Beats without sync are ignored until the next sync.
- reset asserted after 2 beats of a frame, then released and a full frame sent → all outputs at 0 during reset. Only the new frame appears, with no stale s0/s1.
